// File: rtl/oled_spi_write.sv
// rtl/oled_spi_write.sv - SSD1306 4-wire SPI byte transmitter, mode 0, MSB first.
// One byte per ena_write strobe; CS released and write_done pulsed after a CS hold.
module oled_spi_write #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena_write,
  input  logic       dc_in,
  input  logic [7:0] data,
  output logic       write_done,
  output logic       busy,
  output logic       oled_sclk,
  output logic       oled_sdin,
  output logic       oled_cs_n,
  output logic       oled_dc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        sclk_q, sclk_d;
  logic        sdin_q, sdin_d;
  logic        cs_n_q, cs_n_d;
  logic        dc_q, dc_d;
  logic        div_end;

  assign div_end = (div_cnt_q == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      div_cnt_q <= 8'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      sclk_q    <= 1'b0;
      sdin_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      dc_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      sclk_q    <= sclk_d;
      sdin_q    <= sdin_d;
      cs_n_q    <= cs_n_d;
      dc_q      <= dc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    done_d    = done_q;
    busy_d    = busy_q;
    sclk_d    = sclk_q;
    sdin_d    = sdin_q;
    cs_n_d    = cs_n_q;
    dc_d      = dc_q;

    case (state_q)
      S_IDLE: begin
        if (ena_write) begin
          shift_d   = data;
          dc_d      = dc_in;
          cs_n_d    = 1'b0;
          sdin_d    = data[7];
          bit_cnt_d = 3'd0;
          div_cnt_d = 8'd0;
          busy_d    = 1'b1;
          state_d   = S_LOW;
        end
      end
      S_LOW: begin
        if (div_end) begin
          div_cnt_d = 8'd0;
          sclk_d    = 1'b1;
          state_d   = S_HIGH;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      S_HIGH: begin
        if (div_end) begin
          div_cnt_d = 8'd0;
          sclk_d    = 1'b0;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_HOLD;
          end else begin
            // Rotate rather than shift: the bits leaving the top are never reused.
            shift_d   = {shift_q[6:0], shift_q[7]};
            sdin_d    = shift_q[6];
            bit_cnt_d = bit_cnt_q + 3'd1;
            state_d   = S_LOW;
          end
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (div_end) begin
          div_cnt_d = 8'd0;
          cs_n_d    = 1'b1;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign write_done = done_q;
  assign busy       = busy_q;
  assign oled_sclk  = sclk_q;
  assign oled_sdin  = sdin_q;
  assign oled_cs_n  = cs_n_q;
  assign oled_dc    = dc_q;

endmodule
